axis_rr_arbiter: RTL
====================

Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream slave port between M stream masters.
- Sits between several stream master sources and a single stream slave sink.
- Grant is locked for a whole packet, from first beat to the TLAST beat.
- Output TDEST carries the index of the granted source.

Parameters:
- M, default 4: number of requesting input ports (2..16).
- N, default 4: TDATA width in bytes.
- U, default 1: TUSER width in bits.
- IW, default $clog2(M): width of grant index and m_tdest. Derived; not overridable.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- s_tvalid  in  M  per-input TVALID.
- s_tready  out  M  per-input TREADY; at most one bit high.
- s_tdata  in  M*8*N  per-input TDATA; input i at bits [i*8N +: 8N].
- s_tlast  in  M  per-input TLAST.
- s_tuser  in  M*U  per-input TUSER.
- m_tvalid  out  1  output TVALID.
- m_tready  in  1  output TREADY.
- m_tdata  out  8*N  output TDATA.
- m_tlast  out  1  output TLAST.
- m_tuser  out  U  output TUSER.
- m_tdest  out  IW  index of the source of the current beat.
- grant_active  out  1  high while a packet is locked (state PASS).

Behaviour:
- Reset values:
  - state=IDLE, gnt=0, last_gnt=M-1, so input 0 wins first.
  - s_tready=0, m_tvalid=0, m_tdata/m_tlast/m_tuser/m_tdest=0, grant_active=0.
- State IDLE:
  - s_tready=0, m_tvalid=0.
  - If any s_tvalid is set, select the first set bit scanning from last_gnt+1 upward, wrapping modulo M.
  - Register the selection as gnt and go to PASS on the next edge.
  - Exactly one bubble cycle per packet.
- State PASS (combinational path, zero latency):
  - m_tvalid=s_tvalid[gnt] and s_tready[gnt]=m_tready; other s_tready bits are 0.
  - m_tdata/m_tlast/m_tuser are muxed from gnt; m_tdest=gnt.
  - On a handshake (m_tvalid&m_tready) with m_tlast=1: last_gnt<=gnt, go to IDLE.
- Lock rules:
  - s_tvalid[gnt] dropping mid-packet does not release the grant; wait indefinitely.
  - Other requesters are ignored until the TLAST handshake.
- Fairness: a requester that stays asserted is granted within M packets.
- Single-beat packet (TLAST on first beat): PASS lasts one cycle.
- All inputs requesting simultaneously: grant order 0,1,2,3,0,... Sustained throughput = L/(L+1) beats/cycle for packet length L.
- No requesters: remain in IDLE; the last_gnt pointer does not advance.
- Reset asserted mid-packet:
  - All outputs go to reset values asynchronously; the packet is truncated.
  - Upstream and downstream recovery is outside this block's scope.
- AXI rule: m_tvalid never depends on m_tready. Data is stable while m_tvalid & !m_tready, because it is passed straight through from a compliant source.

Optional Feature:
- Macro AXIS_ARB_REG_OUT_EN.
- Defined:
  - Output passes through a 2-entry skid register slice.
  - 1-cycle latency; full throughput; m_* outputs come directly from flops.
  - s_tready[gnt] = slice not full.
  - PASS exits on the input-side TLAST handshake. Arbitration of the next packet overlaps draining of the slice.
- Undefined: combinational pass-through as above; no extra flops.

Decomposition:
- Package axis_arb_pkg:
  - state enum {IDLE, PASS};
  - function rr_pick(req, last) returning the next index;
  - localparam for minimum IW=1.
- Sub-module axis_skid_buffer (2-entry register slice, width 8N+U+IW+1), instantiated only under AXIS_ARB_REG_OUT_EN.

Test Plan:
- Reset: Rst=0 with s_tvalid=4'hF. Require all outputs 0 and no s_tready; after release, first grant goes to input 0, with m_tvalid high 1 cycle after Rst deasserts.
- Round-robin: all 4 inputs send 3-beat packets continuously with m_tready=1. Require m_tdest sequence 0,1,2,3,0 and one idle cycle between packets.
- Lock: input 1 granted and pauses s_tvalid for 5 cycles mid-packet while input 2 requests. Require no switch; input 2 granted only after input 1's TLAST.
- Backpressure: m_tready toggles 1,0,0,1 on 4-beat packet data 32'h11..32'h44. Require m_tdata held during stall; output order 11,22,33,44.
- Single-beat packets: inputs 0 and 3 each send 1-beat packets. Require alternating grants 0,3,0,3 and 2-cycle cadence.
- Mid-packet reset: assert Rst on beat 2 of an input-0 packet. Require m_tvalid=0 immediately and the next grant to be input 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin pick function for the packet arbiter
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam int IW_MIN = 1;
    localparam int M_MAX  = 16;

    // First set request bit strictly after `last`, wrapping modulo m.
    function automatic logic [3:0] rr_pick(input logic [M_MAX-1:0] req,
                                           input logic [3:0]       last,
                                           input int               m);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= M_MAX; k++) begin
            if (k <= m) begin
                idx = (int'(last) + k) % m;
                if (!found && req[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry stream register slice; outputs driven straight from flops
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic [W-1:0] head_q, tail_q;
    logic [1:0]   count_q;
    logic         push, pop;

    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = head_q;
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= s_tdata;
                    else                 tail_q <= s_tdata;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= s_tdata;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= s_tdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-locked round-robin AXI-Stream arbiter; AXIS_ARB_REG_OUT_EN adds an output slice
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int M  = 4,
    parameter  int N  = 4,
    parameter  int U  = 1,
    localparam int IW = ($clog2(M) < IW_MIN) ? IW_MIN : $clog2(M)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [M-1:0]     s_tvalid,
    output logic [M-1:0]     s_tready,
    input  logic [M*8*N-1:0] s_tdata,
    input  logic [M-1:0]     s_tlast,
    input  logic [M*U-1:0]   s_tuser,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [8*N-1:0]   m_tdata,
    output logic             m_tlast,
    output logic [U-1:0]     m_tuser,
    output logic [IW-1:0]    m_tdest,
    output logic             grant_active
);

    localparam int DW = 8 * N;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;

    logic          pass, sel_valid, sel_last, in_ready, in_hs;
    logic [DW-1:0] sel_data;
    logic [U-1:0]  sel_user;

    assign pass         = (state_q == PASS);
    assign sel_valid    = s_tvalid[gnt_q];
    assign sel_last     = s_tlast[gnt_q];
    assign sel_data     = s_tdata[gnt_q*DW +: DW];
    assign sel_user     = s_tuser[gnt_q*U +: U];
    assign in_hs        = pass & sel_valid & in_ready;
    assign s_tready     = pass ? (M'(in_ready) << gnt_q) : '0;
    assign grant_active = pass;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|s_tvalid) begin
                    gnt_d   = IW'(rr_pick(M_MAX'(s_tvalid), 4'(last_q), M));
                    state_d = PASS;
                end
            end
            PASS: begin
                // The grant is held until the TLAST beat is accepted, regardless of gaps in valid.
                if (in_hs && sel_last) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(M - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_ARB_REG_OUT_EN
    localparam int SW = DW + U + IW + 1;
    logic [SW-1:0] slice_out;

    axis_skid_buffer #(.W(SW)) u_slice (
        .Clk      (Clk),
        .Rst      (Rst),
        .s_tdata  ({gnt_q, sel_user, sel_last, sel_data}),
        .s_tvalid (pass & sel_valid),
        .s_tready (in_ready),
        .m_tdata  (slice_out),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    assign {m_tdest, m_tuser, m_tlast, m_tdata} = slice_out;
`else
    assign in_ready = m_tready;
    assign m_tvalid = pass & sel_valid;
    assign m_tdata  = pass ? sel_data : '0;
    assign m_tlast  = pass & sel_last;
    assign m_tuser  = pass ? sel_user : '0;
    assign m_tdest  = pass ? gnt_q : '0;
`endif

endmodule
